// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the mips run/step controller: run modes, stop causes, FSM states.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        MODE_STEP  = 2'd0,
        MODE_FREE  = 2'd1,
        MODE_BREAK = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        STOP_COUNT = 2'd0,
        STOP_HALT  = 2'd1,
        STOP_BP    = 2'd2
    } stop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // The unused raw encoding 3 behaves as a free run.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd0:    decode_mode = MODE_STEP;
            2'd2:    decode_mode = MODE_BREAK;
            default: decode_mode = MODE_FREE;
        endcase
    endfunction

endpackage

// File: rtl/mips_trace_fifo.sv
// Circular trace buffer: overwrites the oldest entry when full and flags it on o_ovf.
module mips_trace_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    input  logic          i_clr_ovf,
    output logic [W-1:0]  o_dout,
    output logic          o_empty,
    output logic [AW:0]   o_level,
    output logic          o_ovf
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_level;
    logic          r_ovf;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_rd_adv;

    assign w_full   = (r_level == FULL_LVL);
    assign w_empty  = (r_level == '0);
    assign w_pop    = i_pop && !w_empty;
    // A push into a full buffer drops the oldest entry, so the read side moves too.
    assign w_rd_adv = w_pop || (i_push && w_full);

    // NOTE: the storage array has no reset; validity is tracked by r_level alone,
    // which keeps the array a plain RAM with no reset fan-out.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_rd_adv) begin
                r_rd <= r_rd + AW'(1);
            end
            if (i_push && !w_full && !w_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (!i_push && w_pop) begin
                r_level <= r_level - (AW+1)'(1);
            end
            if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end else if (i_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_dout  = w_empty ? '0 : r_mem[r_rd];
    assign o_empty = w_empty;
    assign o_level = r_level;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/step/breakpoint controller gating the mips core via cpu_en, with optional
// trace capture enabled by defining MIPS_RUN_CTRL_TRACE_EN.
module mips_run_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int STEP_W      = 16,
    parameter int TRACE_DEPTH = 8,
    localparam int TRACE_AW   = $clog2(TRACE_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [STEP_W-1:0]   step_count,
    input  logic [DATA_W-1:0]   bp_addr,
    input  logic                halt_req,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic [DATA_W-1:0]   alu_in,
    output logic                cpu_en,
    output logic                busy,
    output logic                done,
    output logic [1:0]          stop_cause,
    output logic [STEP_W-1:0]   steps_done,
    input  logic                trace_rd,
    output logic [DATA_W-1:0]   trace_pc,
    output logic [DATA_W-1:0]   trace_alu,
    output logic                trace_empty,
    output logic [TRACE_AW:0]   trace_level,
    output logic                trace_ovf
);

    state_e              r_state;
    state_e              w_state_nxt;
    mode_e               r_mode;
    logic [STEP_W-1:0]   r_remaining;
    logic [STEP_W-1:0]   r_steps_done;
    logic [DATA_W-1:0]   r_bp;
    stop_e               r_stop_cause;
    stop_e               w_cause;
    logic                w_stop_halt;
    logic                w_stop_bp;
    logic                w_stop_cnt;
    logic                w_stop;
    logic                w_cpu_en;
    logic                w_start_acc;

    assign w_stop_halt = halt_req;
    assign w_stop_bp   = (r_mode == MODE_BREAK) && (pc_in == r_bp);
    assign w_stop_cnt  = (r_mode == MODE_STEP) && (r_remaining == '0);
    assign w_stop      = w_stop_halt || w_stop_bp || w_stop_cnt;
    assign w_start_acc = (r_state == S_IDLE) && start;

    // NOTE: every combinational output gets a default first, so no path leaves
    // one unassigned and no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cpu_en    = 1'b0;
        w_cause     = STOP_COUNT;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_cpu_en = !w_stop;
                if (w_stop) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_stop_halt) begin
            w_cause = STOP_HALT;
        end else if (w_stop_bp) begin
            w_cause = STOP_BP;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= MODE_STEP;
            r_remaining  <= '0;
            r_bp         <= '0;
            r_steps_done <= '0;
            r_stop_cause <= STOP_COUNT;
        end else begin
            if (w_start_acc) begin
                r_mode       <= decode_mode(mode);
                r_remaining  <= step_count;
                r_bp         <= bp_addr;
                r_steps_done <= '0;
            end else if (w_cpu_en) begin
                r_remaining <= r_remaining - STEP_W'(1);
                if (r_steps_done != '1) begin
                    r_steps_done <= r_steps_done + STEP_W'(1);
                end
            end
            if ((r_state == S_RUN) && w_stop) begin
                r_stop_cause <= w_cause;
            end
        end
    end

    assign cpu_en     = w_cpu_en;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign stop_cause = r_stop_cause;
    assign steps_done = r_steps_done;

`ifdef MIPS_RUN_CTRL_TRACE_EN
    logic [2*DATA_W-1:0] w_trace_dout;

    mips_trace_fifo #(
        .W     (2*DATA_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_cpu_en),
        .i_din     ({pc_in, alu_in}),
        .i_pop     (trace_rd),
        .i_clr_ovf (w_start_acc),
        .o_dout    (w_trace_dout),
        .o_empty   (trace_empty),
        .o_level   (trace_level),
        .o_ovf     (trace_ovf)
    );

    assign trace_pc  = w_trace_dout[2*DATA_W-1:DATA_W];
    assign trace_alu = w_trace_dout[DATA_W-1:0];
`else
    // Without capture the pop strobe and ALU result have no consumer.
    logic w_unused_trace;
    assign w_unused_trace = ^{trace_rd, alu_in};

    assign trace_pc    = '0;
    assign trace_alu   = '0;
    assign trace_empty = 1'b1;
    assign trace_level = '0;
    assign trace_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: directed scenarios plus randomized runs
// against an outcome-level model (steps = first of count/breakpoint/halt) and a trace queue.
module tb_mips_run_ctrl;

    localparam int DATA_W      = 32;
    localparam int STEP_W      = 4;
    localparam int TRACE_DEPTH = 8;
    localparam int TRACE_AW    = 3;
    localparam int SAT         = 15;
`ifdef MIPS_RUN_CTRL_TRACE_EN
    localparam bit TRACE_EN = 1'b1;
`else
    localparam bit TRACE_EN = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                start;
    logic [1:0]          mode;
    logic [STEP_W-1:0]   step_count;
    logic [DATA_W-1:0]   bp_addr;
    logic                halt_req;
    logic [DATA_W-1:0]   pc_in;
    logic [DATA_W-1:0]   alu_in;
    logic                cpu_en;
    logic                busy;
    logic                done;
    logic [1:0]          stop_cause;
    logic [STEP_W-1:0]   steps_done;
    logic                trace_rd;
    logic [DATA_W-1:0]   trace_pc;
    logic [DATA_W-1:0]   trace_alu;
    logic                trace_empty;
    logic [TRACE_AW:0]   trace_level;
    logic                trace_ovf;

    mips_run_ctrl #(
        .DATA_W      (DATA_W),
        .STEP_W      (STEP_W),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .step_count  (step_count),
        .bp_addr     (bp_addr),
        .halt_req    (halt_req),
        .pc_in       (pc_in),
        .alu_in      (alu_in),
        .cpu_en      (cpu_en),
        .busy        (busy),
        .done        (done),
        .stop_cause  (stop_cause),
        .steps_done  (steps_done),
        .trace_rd    (trace_rd),
        .trace_pc    (trace_pc),
        .trace_alu   (trace_alu),
        .trace_empty (trace_empty),
        .trace_level (trace_level),
        .trace_ovf   (trace_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    logic [63:0] q[$];
    bit          m_ovf;
    int          m_steps;
    int          m_cause;

    function automatic logic [69:0] exp_trace();
        logic [63:0] head;
        head = (q.size() > 0) ? q[0] : 64'h0;
        return {q.size() == 0, (TRACE_AW+1)'(q.size()), m_ovf, head};
    endfunction

    function automatic logic [STEP_W-1:0] exp_steps_done();
        return (m_steps > SAT) ? STEP_W'(SAT) : STEP_W'(m_steps);
    endfunction

    // One run from start to back in IDLE. Expected outcome is derived up front:
    // the run stops at the earliest of count, breakpoint position and halt cycle.
    task automatic run_one(input string name, input logic [1:0] md, input int n,
                           input logic [31:0] bp, input logic [31:0] p0, input int h,
                           input logic [31:0] pop_mask, input int start_mid);
        int          steps;
        int          kbp;
        int          cause;
        int          sm;
        logic [31:0] diff;
        logic [2:0]  exp_ctl;
        logic [69:0] act_tr;
        logic [69:0] exp_tr;

        steps = (h >= 0) ? h : 1000;
        if (md == 2'd0 && n < steps) steps = n;
        diff = bp - p0;
        kbp  = (md == 2'd2 && bp >= p0 && diff[1:0] == 2'b00 && diff < 32'd4000) ? int'(diff >> 2) : -1;
        if (kbp >= 0 && kbp < steps) steps = kbp;
        if (steps == h) cause = 1;
        else if (steps == kbp) cause = 2;
        else cause = 0;
        sm = (start_mid <= steps + 1) ? start_mid : -1;

        start = 1'b1; mode = md; step_count = STEP_W'(n); bp_addr = bp;
        pc_in = p0; alu_in = $urandom; halt_req = 1'b0; trace_rd = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cpu_en, busy, done} !== 3'b000) begin
            n_bad++;
            $display("FAIL %s start-cycle ctl: got %b want 000", name, {cpu_en, busy, done});
        end
        @(posedge clk); #1;
        m_ovf = 1'b0; m_steps = 0;
        start = 1'b0;

        for (int i = 0; i <= steps + 2; i++) begin
            pc_in    = p0 + 32'(4 * ((i < steps) ? i : steps));
            alu_in   = $urandom;
            halt_req = (i == h);
            trace_rd = (i < 32) ? pop_mask[i] : 1'b0;
            start    = (i == sm);
            if (i == sm) begin
                mode = 2'd0; step_count = '0;
            end
            exp_ctl = {i < steps, i <= steps + 1, i == steps + 1};
            @(negedge clk);
            n_cmp++;
            if ({cpu_en, busy, done} !== exp_ctl) begin
                n_bad++;
                $display("FAIL %s ctl cyc %0d: got cpu_en/busy/done %b want %b", name, i, {cpu_en, busy, done}, exp_ctl);
            end
            n_cmp++;
            if (steps_done !== exp_steps_done()) begin
                n_bad++;
                $display("FAIL %s steps_done cyc %0d: got %0d want %0d", name, i, steps_done, exp_steps_done());
            end
            act_tr = {trace_empty, trace_level, trace_ovf, trace_pc, trace_alu};
            exp_tr = exp_trace();
            n_cmp++;
            if (act_tr !== exp_tr) begin
                n_bad++;
                $display("FAIL %s trace cyc %0d: got %h want %h", name, i, act_tr, exp_tr);
            end
            if (i > steps) begin
                n_cmp++;
                if (stop_cause !== 2'(m_cause)) begin
                    n_bad++;
                    $display("FAIL %s stop_cause cyc %0d: got %0d want %0d", name, i, stop_cause, m_cause);
                end
            end
            if (TRACE_EN) begin
                if (trace_rd && q.size() > 0) void'(q.pop_front());
                if (i < steps) begin
                    q.push_back({pc_in, alu_in});
                    if (q.size() > TRACE_DEPTH) begin
                        void'(q.pop_front());
                        m_ovf = 1'b1;
                    end
                end
            end
            if (i < steps) m_steps++;
            if (i == steps) m_cause = cause;
            @(posedge clk); #1;
        end
        start = 1'b0; halt_req = 1'b0; trace_rd = 1'b0;
    endtask

    task automatic drain_trace(input string name);
        logic [69:0] act_tr;
        logic [69:0] exp_tr;
        for (int i = 0; i < TRACE_DEPTH + 2; i++) begin
            trace_rd = 1'b1;
            @(negedge clk);
            act_tr = {trace_empty, trace_level, trace_ovf, trace_pc, trace_alu};
            exp_tr = exp_trace();
            n_cmp++;
            if (act_tr !== exp_tr) begin
                n_bad++;
                $display("FAIL %s pop %0d: got %h want %h", name, i, act_tr, exp_tr);
            end
            if (q.size() > 0) void'(q.pop_front());
            @(posedge clk); #1;
        end
        trace_rd = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        logic [11:0] act_v;
        n_cmp++;
        act_v = {cpu_en, busy, done, stop_cause, steps_done, trace_empty, trace_ovf};
        if (act_v !== 12'b000_00_0000_1_0) begin
            n_bad++;
            $display("FAIL %s ctl/status: got %b want 000000000010", name, act_v);
        end
        n_cmp++;
        if ({trace_level, trace_pc, trace_alu} !== '0) begin
            n_bad++;
            $display("FAIL %s trace regs: got level %0d pc %h alu %h want all 0", name, trace_level, trace_pc, trace_alu);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 2'd0; step_count = '0; bp_addr = '0;
        halt_req = 1'b0; pc_in = '0; alu_in = '0; trace_rd = 1'b0;
        q.delete(); m_ovf = 1'b0; m_steps = 0; m_cause = 0;
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_step_n();
        run_one("step3", 2'd0, 3, 32'h0, 32'h0, -1, 32'h0, -1);
        drain_trace("step3_drain");
    endtask

    task automatic test_step_zero();
        run_one("step0", 2'd0, 0, 32'h0, 32'h40, -1, 32'h0, -1);
    endtask

    task automatic test_break();
        run_one("break", 2'd2, 0, 32'h10, 32'h0, -1, 32'h0, -1);
        run_one("break_at_start", 2'd2, 0, 32'h10, 32'h10, -1, 32'h0, -1);
        drain_trace("break_drain");
    endtask

    task automatic test_free_halt();
        run_one("free_halt", 2'd1, 0, 32'h0, 32'h0, 5, 32'h0, -1);
        run_one("halt_and_bp", 2'd2, 0, 32'h14, 32'h0, 5, 32'h0, -1);
        run_one("mode3_halt", 2'd3, 2, 32'h0, 32'h80, 4, 32'h0, -1);
        drain_trace("halt_drain");
    endtask

    task automatic test_overflow();
        run_one("ovf_step10", 2'd0, 10, 32'h0, 32'h0, -1, 32'h0, -1);
        run_one("push_pop_full", 2'd0, 2, 32'h0, 32'h200, -1, 32'h1, -1);
        drain_trace("ovf_drain");
    endtask

    task automatic test_saturation();
        run_one("saturate", 2'd1, 0, 32'h0, 32'h0, 18, 32'h0, -1);
        drain_trace("sat_drain");
    endtask

    task automatic test_back_to_back_start();
        run_one("start_in_run", 2'd0, 6, 32'h0, 32'h300, -1, 32'h0, 2);
        run_one("start_in_done", 2'd0, 6, 32'h0, 32'h300, -1, 32'h0, 7);
        drain_trace("start_drain");
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; mode = 2'd0; step_count = STEP_W'(10); pc_in = 32'h100; alu_in = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (cpu_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid pre-reset cpu_en: got %b want 1", cpu_en);
        end
        #2 rst = 1'b1;
        #1;
        q.delete(); m_ovf = 1'b0; m_steps = 0; m_cause = 0;
        check_reset_values("rst_mid_async");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({done, busy, cpu_en} !== 3'b000) begin
                n_bad++;
                $display("FAIL rst_mid held %0d: got done/busy/cpu_en %b want 000", i, {done, busy, cpu_en});
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({done, busy, cpu_en} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_mid after release: got done/busy/cpu_en %b want 000", {done, busy, cpu_en});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [1:0]  md;
        int          n;
        int          h;
        int          sm;
        logic [31:0] p0;
        logic [31:0] bp;
        for (int r = 0; r < 25; r++) begin
            md = 2'($urandom_range(0, 3));
            n  = $urandom_range(0, 12);
            p0 = 32'($urandom_range(0, 64) * 4);
            bp = ($urandom_range(0, 3) == 0) ? p0 + 32'd1 : p0 + 32'($urandom_range(0, 12) * 4);
            h  = $urandom_range(0, 20);
            if (md == 2'd0 && $urandom_range(0, 1) == 1) h = -1;
            sm = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : -1;
            run_one($sformatf("rand%0d", r), md, n, bp, p0, h, $urandom & $urandom, sm);
        end
        drain_trace("rand_drain");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_step_n();
        test_step_zero();
        test_break();
        test_free_halt();
        test_overflow();
        test_saturation();
        test_back_to_back_start();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
